spi_cmd_decoder: RTL and testbench
==================================

Name: spi_cmd_decoder

Overview:
- Sits directly downstream of the SPI slave receiver inside Main.
- Consumes the 16-bit words that receiver deserialises from MOSI and parses them into framed drawing commands.
- Presents each complete command on a valid/ready bus to the rasterizer/framebuffer control.
- The receiver has no backpressure, so this block owns packet framing, resynchronisation and overflow detection.

Parameters:
- CORDW, 16, coordinate/operand width; must equal SPI word width.
- OPW, 4, opcode field width, taken from header bits [15:12].

Ports:
- clock  input  1  system clock; the single clock for the whole block.
- reset  input  1  synchronous, active-high reset.
- io_word  input  16  word from SPI receiver.
- io_word_valid  input  1  one-cycle pulse per received word.
- io_cs_active  input  1  SPI chip-select asserted (frame open), already synchronised to clock.
- io_cmd_valid  output  1  command slot holds a complete command.
- io_cmd_ready  input  1  consumer accepts the command.
- io_cmd_op  output  OPW  opcode of the held command.
- io_cmd_x0, io_cmd_y0, io_cmd_x1, io_cmd_y1  output  CORDW each  operands.
- io_err_clear  input  1  clears sticky error flags.
- io_err_overflow  output  1  sticky: a complete command was dropped because the slot was full.
- io_err_abort  output  1  sticky: frame closed mid-packet.
- io_err_opcode  output  1  sticky: undefined opcode received.

Behaviour:
- Reset (synchronous, takes priority over all inputs):
  - State goes to HEADER.
  - All outputs, operand registers and the operand counter go to 0.
- Header word: opcode = word[15:12]; word[11:0] is ignored.
  - 0x0 NOP: zero operands; discarded with no output.
  - 0x1 LINE: 4 operands, received as x0, y0, x1, y1.
  - 0x2 CLEAR: 1 operand, the colour, placed on io_cmd_x0; other operand outputs are 0.
  - 0x3 SWAP: zero operands; emitted immediately with all operand outputs 0.
  - Any other opcode: set io_err_opcode, discard the word, remain in HEADER.
- State machine has two states, HEADER and OPERAND.
  - HEADER → OPERAND on a valid header whose opcode has ≥1 operand; load the remaining-operand counter.
  - In OPERAND, each io_word_valid stores the word in the next operand register and decrements the counter.
  - When the counter reaches 0, the command completes and the state returns to HEADER.
- Completion and latency:
  - io_cmd_valid rises on the cycle after the final word's io_word_valid.
  - For SWAP it rises on the cycle after the header.
- Handshake:
  - A transfer occurs when io_cmd_valid && io_cmd_ready.
  - io_cmd_* outputs are held stable while io_cmd_valid=1 and not yet accepted.
  - io_cmd_valid deasserts on the cycle after the transfer unless a new command loads in that same cycle.
- Simultaneous accept and complete: if the slot is accepted in the same cycle a new command completes, the new command loads.
  - io_cmd_valid stays 1 with no bubble.
  - No overflow is flagged.
- Overflow: if a command completes while the slot is full and not being accepted:
  - The new command is dropped and io_err_overflow is set.
  - The held command is unchanged.
  - Parsing continues in HEADER.
- Operand capture uses separate shadow registers, so receiving operands never disturbs the held slot.
- Frame abort: io_cs_active=0 while in OPERAND discards the partial packet, sets io_err_abort and returns to HEADER on the next cycle.
  - A word with io_word_valid in that same cycle is ignored.
  - io_cs_active=0 in HEADER has no effect.
- Words arriving while io_cs_active=0 are ignored in all states.
- Error flags:
  - Sticky until io_err_clear=1, which clears them on the next edge.
  - If set and clear occur in the same cycle, set wins.
- Back-to-back words on consecutive cycles must be accepted; there is no minimum gap.

Test Plan:
- Reset, then words 0x0000, 0x0000 (NOPs) → io_cmd_valid stays 0, all error flags 0.
- cs=1; words 0x1000, 0x0064, 0x0064, 0x00C8, 0x0032 → one cycle after the last word: op=1, x0=100, y0=100, x1=200, y1=50, valid=1; it holds until ready=1, then valid=0 on the next cycle.
- With ready=0, send LINE (1,2,3,4) then CLEAR 0x00FF → the slot keeps LINE (1,2,3,4), io_err_overflow=1; io_err_clear pulse → flag returns to 0.
- Send 0x1000, 0x0005, then drop cs for 1 cycle, then 0x3000 → io_err_abort=1, then a SWAP command with op=3 and all operands 0.
- Held LINE with ready asserted in the same cycle the final CLEAR operand 0x0ABC arrives → the next cycle shows op=2, x0=0x0ABC, valid continuously 1, overflow=0.
- Header 0x7000, then 0x3000 → io_err_opcode=1, followed by a normal SWAP command.

Source files
------------

// File: rtl/spi_cmd_decoder_if.sv
// Bus between the SPI word receiver, the command decoder and the raster
// control: incoming word stream, outgoing command slot and sticky errors.
interface spi_cmd_decoder_if #(
  parameter int CORDW = 16,
  parameter int OPW   = 4
);
  logic [CORDW-1:0] io_word;
  logic             io_word_valid;
  logic             io_cs_active;
  logic             io_cmd_valid;
  logic             io_cmd_ready;
  logic [OPW-1:0]   io_cmd_op;
  logic [CORDW-1:0] io_cmd_x0;
  logic [CORDW-1:0] io_cmd_y0;
  logic [CORDW-1:0] io_cmd_x1;
  logic [CORDW-1:0] io_cmd_y1;
  logic             io_err_clear;
  logic             io_err_overflow;
  logic             io_err_abort;
  logic             io_err_opcode;

  // Decoder side
  modport slave (
    input  io_word, io_word_valid, io_cs_active, io_cmd_ready, io_err_clear,
    output io_cmd_valid, io_cmd_op, io_cmd_x0, io_cmd_y0, io_cmd_x1, io_cmd_y1,
           io_err_overflow, io_err_abort, io_err_opcode
  );

  // Word source / command consumer side
  modport master (
    output io_word, io_word_valid, io_cs_active, io_cmd_ready, io_err_clear,
    input  io_cmd_valid, io_cmd_op, io_cmd_x0, io_cmd_y0, io_cmd_x1, io_cmd_y1,
           io_err_overflow, io_err_abort, io_err_opcode
  );
endinterface

// File: rtl/spi_cmd_decoder.sv
// Parses the 16-bit SPI word stream into framed drawing commands and holds
// each finished command in a single valid/ready slot. The receiver cannot be
// stalled, so framing, resync on chip-select drop and overflow live here.
module spi_cmd_decoder #(
  parameter int CORDW = 16,
  parameter int OPW   = 4
) (
  input  logic              clock,
  input  logic              reset,
  spi_cmd_decoder_if.slave  bus
);

  localparam logic [OPW-1:0] OP_NOP   = OPW'(0);
  localparam logic [OPW-1:0] OP_LINE  = OPW'(1);
  localparam logic [OPW-1:0] OP_CLEAR = OPW'(2);
  localparam logic [OPW-1:0] OP_SWAP  = OPW'(3);

  typedef enum logic {S_HEADER, S_OPERAND} state_t;

  state_t           state;
  logic [2:0]       rem_cnt;
  logic [1:0]       opnd_idx;

  // Shadow (in-flight) command, separate from the held slot
  logic [OPW-1:0]   sh_op;
  logic [CORDW-1:0] sh_x0, sh_y0, sh_x1, sh_y1;

  logic [OPW-1:0]   nx_op;
  logic [CORDW-1:0] nx_x0, nx_y0, nx_x1, nx_y1;
  logic [OPW-1:0]   hdr_op;
  logic             word_ok;
  logic             start_pkt;
  logic             complete;
  logic             bad_op;
  logic             abort;
  logic             accept;
  logic             can_load;

  assign hdr_op   = bus.io_word[CORDW-1 -: OPW];
  assign word_ok  = bus.io_word_valid & bus.io_cs_active;
  assign accept   = bus.io_cmd_valid & bus.io_cmd_ready;
  assign can_load = ~bus.io_cmd_valid | bus.io_cmd_ready;

  // Decode the current word: next shadow contents and packet events
  always_comb begin
    nx_op     = sh_op;
    nx_x0     = sh_x0;
    nx_y0     = sh_y0;
    nx_x1     = sh_x1;
    nx_y1     = sh_y1;
    start_pkt = 1'b0;
    complete  = 1'b0;
    bad_op    = 1'b0;
    abort     = 1'b0;
    case (state)
      S_HEADER: begin
        if (word_ok) begin
          // A fresh header zeroes the shadow so unused operands read as 0
          nx_op = hdr_op;
          nx_x0 = '0;
          nx_y0 = '0;
          nx_x1 = '0;
          nx_y1 = '0;
          case (hdr_op)
            OP_NOP:            ;
            OP_LINE, OP_CLEAR: start_pkt = 1'b1;
            OP_SWAP:           complete  = 1'b1;
            default:           bad_op    = 1'b1;
          endcase
        end
      end
      S_OPERAND: begin
        if (!bus.io_cs_active) begin
          abort = 1'b1;
        end else if (bus.io_word_valid) begin
          case (opnd_idx)
            2'd0:    nx_x0 = bus.io_word;
            2'd1:    nx_y0 = bus.io_word;
            2'd2:    nx_x1 = bus.io_word;
            default: nx_y1 = bus.io_word;
          endcase
          complete = (rem_cnt == 3'd1);
        end
      end
      default: ;
    endcase
  end

  // Packet framing FSM: header/operand sequencing and operand counting
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= S_HEADER;
      rem_cnt  <= '0;
      opnd_idx <= '0;
    end else begin
      case (state)
        S_HEADER: begin
          if (start_pkt) begin
            state    <= S_OPERAND;
            rem_cnt  <= (hdr_op == OP_LINE) ? 3'd4 : 3'd1;
            opnd_idx <= '0;
          end
        end
        S_OPERAND: begin
          if (abort) begin
            state   <= S_HEADER;
            rem_cnt <= '0;
          end else if (bus.io_word_valid) begin
            rem_cnt  <= rem_cnt - 3'd1;
            opnd_idx <= opnd_idx + 2'd1;
            if (complete) state <= S_HEADER;
          end
        end
        default: state <= S_HEADER;
      endcase
    end
  end

  // Shadow operand capture
  always_ff @(posedge clock) begin
    if (reset) begin
      sh_op <= '0;
      sh_x0 <= '0;
      sh_y0 <= '0;
      sh_x1 <= '0;
      sh_y1 <= '0;
    end else begin
      sh_op <= nx_op;
      sh_x0 <= nx_x0;
      sh_y0 <= nx_y0;
      sh_x1 <= nx_x1;
      sh_y1 <= nx_y1;
    end
  end

  // Output slot: load on completion when free or draining, else hold
  always_ff @(posedge clock) begin
    if (reset) begin
      bus.io_cmd_valid <= 1'b0;
      bus.io_cmd_op    <= '0;
      bus.io_cmd_x0    <= '0;
      bus.io_cmd_y0    <= '0;
      bus.io_cmd_x1    <= '0;
      bus.io_cmd_y1    <= '0;
    end else if (complete && can_load) begin
      bus.io_cmd_valid <= 1'b1;
      bus.io_cmd_op    <= nx_op;
      bus.io_cmd_x0    <= nx_x0;
      bus.io_cmd_y0    <= nx_y0;
      bus.io_cmd_x1    <= nx_x1;
      bus.io_cmd_y1    <= nx_y1;
    end else if (accept) begin
      bus.io_cmd_valid <= 1'b0;
    end
  end

  // Sticky error flags; a new event in the clear cycle keeps the flag set
  always_ff @(posedge clock) begin
    if (reset) begin
      bus.io_err_overflow <= 1'b0;
      bus.io_err_abort    <= 1'b0;
      bus.io_err_opcode   <= 1'b0;
    end else begin
      bus.io_err_overflow <= (complete & ~can_load) |
                             (bus.io_err_overflow & ~bus.io_err_clear);
      bus.io_err_abort    <= abort  | (bus.io_err_abort  & ~bus.io_err_clear);
      bus.io_err_opcode   <= bad_op | (bus.io_err_opcode & ~bus.io_err_clear);
    end
  end

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Directed bench for spi_cmd_decoder: inputs change and outputs are sampled
// on the falling clock edge.
module tb_spi_cmd_decoder;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  spi_cmd_decoder_if #(.CORDW(16), .OPW(4)) bus ();

  spi_cmd_decoder #(.CORDW(16), .OPW(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_cmd(input string tag, input logic [3:0] op,
                         input logic [15:0] x0, input logic [15:0] y0,
                         input logic [15:0] x1, input logic [15:0] y1);
    chk({tag, ".valid"}, 32'(bus.io_cmd_valid), 32'd1);
    chk({tag, ".op"},    32'(bus.io_cmd_op),    32'(op));
    chk({tag, ".x0"},    32'(bus.io_cmd_x0),    32'(x0));
    chk({tag, ".y0"},    32'(bus.io_cmd_y0),    32'(y0));
    chk({tag, ".x1"},    32'(bus.io_cmd_x1),    32'(x1));
    chk({tag, ".y1"},    32'(bus.io_cmd_y1),    32'(y1));
  endtask

  // Present one word for one cycle; consecutive calls are back-to-back
  task automatic word_cycle(input logic [15:0] w);
    bus.io_word       = w;
    bus.io_word_valid = 1'b1;
    @(negedge clock);
    bus.io_word_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic drain();
    bus.io_cmd_ready = 1'b1;
    @(negedge clock);
    bus.io_cmd_ready = 1'b0;
  endtask

  task automatic pulse_clear();
    bus.io_err_clear = 1'b1;
    @(negedge clock);
    bus.io_err_clear = 1'b0;
  endtask

  initial begin
    reset             = 1'b1;
    bus.io_word       = '0;
    bus.io_word_valid = 1'b0;
    bus.io_cs_active  = 1'b0;
    bus.io_cmd_ready  = 1'b0;
    bus.io_err_clear  = 1'b0;
    idle(2);

    chk("rst.valid", 32'(bus.io_cmd_valid),    32'd0);
    chk("rst.op",    32'(bus.io_cmd_op),       32'd0);
    chk("rst.x0",    32'(bus.io_cmd_x0),       32'd0);
    chk("rst.y1",    32'(bus.io_cmd_y1),       32'd0);
    chk("rst.ovf",   32'(bus.io_err_overflow), 32'd0);
    chk("rst.abort", 32'(bus.io_err_abort),    32'd0);
    chk("rst.opc",   32'(bus.io_err_opcode),   32'd0);
    reset            = 1'b0;
    bus.io_cs_active = 1'b1;
    idle(1);

    // NOP headers produce nothing
    word_cycle(16'h0000);
    word_cycle(16'h0000);
    idle(1);
    chk("nop.valid", 32'(bus.io_cmd_valid),    32'd0);
    chk("nop.ovf",   32'(bus.io_err_overflow), 32'd0);
    chk("nop.abort", 32'(bus.io_err_abort),    32'd0);
    chk("nop.opc",   32'(bus.io_err_opcode),   32'd0);

    // LINE 100,100,200,50 back-to-back, held until accepted
    word_cycle(16'h1000);
    chk("line.mid_valid", 32'(bus.io_cmd_valid), 32'd0);
    word_cycle(16'h0064);
    word_cycle(16'h0064);
    word_cycle(16'h00C8);
    word_cycle(16'h0032);
    chk_cmd("line", 4'd1, 16'd100, 16'd100, 16'd200, 16'd50);
    idle(2);
    chk_cmd("line.hold", 4'd1, 16'd100, 16'd100, 16'd200, 16'd50);
    drain();
    chk("line.after_accept", 32'(bus.io_cmd_valid), 32'd0);

    // Overflow: CLEAR completes while LINE 1,2,3,4 sits unaccepted
    word_cycle(16'h1000);
    word_cycle(16'h0001);
    word_cycle(16'h0002);
    word_cycle(16'h0003);
    word_cycle(16'h0004);
    chk("ovf.pre", 32'(bus.io_err_overflow), 32'd0);
    word_cycle(16'h2000);
    word_cycle(16'h00FF);
    chk("ovf.flag", 32'(bus.io_err_overflow), 32'd1);
    chk_cmd("ovf.slot", 4'd1, 16'd1, 16'd2, 16'd3, 16'd4);
    pulse_clear();
    chk("ovf.cleared", 32'(bus.io_err_overflow), 32'd0);
    drain();
    chk("ovf.drained", 32'(bus.io_cmd_valid), 32'd0);

    // Abort: cs drops mid-LINE; the word offered during the drop is ignored
    word_cycle(16'h1000);
    word_cycle(16'h0005);
    bus.io_cs_active = 1'b0;
    word_cycle(16'h0006);
    bus.io_cs_active = 1'b1;
    chk("abort.flag",  32'(bus.io_err_abort),  32'd1);
    chk("abort.valid", 32'(bus.io_cmd_valid),  32'd0);
    word_cycle(16'h3000);
    chk_cmd("abort.swap", 4'd3, 16'd0, 16'd0, 16'd0, 16'd0);
    chk("abort.sticky", 32'(bus.io_err_abort), 32'd1);
    pulse_clear();
    chk("abort.cleared", 32'(bus.io_err_abort), 32'd0);
    drain();

    // Accept and complete in the same cycle: no bubble, no overflow
    word_cycle(16'h1000);
    word_cycle(16'h0001);
    word_cycle(16'h0002);
    word_cycle(16'h0003);
    word_cycle(16'h0004);
    word_cycle(16'h2000);
    chk("sim.valid_mid", 32'(bus.io_cmd_valid), 32'd1);
    bus.io_cmd_ready = 1'b1;
    word_cycle(16'h0ABC);
    bus.io_cmd_ready = 1'b0;
    chk_cmd("sim.clear", 4'd2, 16'h0ABC, 16'd0, 16'd0, 16'd0);
    chk("sim.ovf", 32'(bus.io_err_overflow), 32'd0);
    drain();
    chk("sim.drained", 32'(bus.io_cmd_valid), 32'd0);

    // Undefined opcode, then a normal SWAP
    word_cycle(16'h7000);
    chk("opc.flag",  32'(bus.io_err_opcode), 32'd1);
    chk("opc.valid", 32'(bus.io_cmd_valid),  32'd0);
    word_cycle(16'h3000);
    chk_cmd("opc.swap", 4'd3, 16'd0, 16'd0, 16'd0, 16'd0);
    drain();

    // Header offered with cs inactive is ignored
    bus.io_cs_active = 1'b0;
    word_cycle(16'h3000);
    bus.io_cs_active = 1'b1;
    idle(1);
    chk("cs_off.valid", 32'(bus.io_cmd_valid), 32'd0);

    // Opcode error raised in the same cycle as a clear stays set
    bus.io_err_clear = 1'b1;
    word_cycle(16'h9000);
    bus.io_err_clear = 1'b0;
    chk("opc.set_wins", 32'(bus.io_err_opcode), 32'd1);
    pulse_clear();
    chk("opc.cleared", 32'(bus.io_err_opcode), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
